// File: rtl/rv_core_pkg.sv
// Shared core definitions: register-file geometry, writeback payload and arbitration modes.
package rv_core_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREG      = 32;
    localparam int unsigned REG_IDX_W = $clog2(NREG);

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      wd;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard: reservation at issue, clear at commit, hazard lookups.
module rf_scoreboard
    import rv_core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rsv_valid,
    input  logic [REG_IDX_W-1:0] rsv_rd,
    output logic                 rsv_ready,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy
);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic            set_en;

    assign rsv_ready = ~pend[rsv_rd];
    assign set_en    = rsv_valid & rsv_ready;
    assign rs1_busy  = pend[rs1];
    assign rs2_busy  = pend[rs2];

    // Set is applied after clear so a new producer wins over a retiring one; x0 never pends.
    always_comb begin
        pend_nxt = pend;
        if (clr_en) begin
            pend_nxt[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pend_nxt[rsv_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback and tracks pending writes.
module rf_write_arbiter
    import rv_core_pkg::*;
#(
    parameter int unsigned PRIO_MODE = PRIO_RR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_wd,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [REG_IDX_W-1:0] ld_rd,
    input  logic [XLEN-1:0]      ld_wd,
    input  logic                 rsv_valid,
    output logic                 rsv_ready,
    input  logic [REG_IDX_W-1:0] rsv_rd,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 RFwr,
    output logic [REG_IDX_W-1:0] rd,
    output logic [XLEN-1:0]      WD
);

    wb_src_e rr_last;
    wb_src_e rr_last_nxt;
    wb_req_t alu_req;
    wb_req_t ld_req;
    wb_req_t win_req;
    logic    grant_alu;
    logic    grant_ld;
    logic    grant;
    logic    commit_c;

    assign alu_req = '{rd: alu_rd, wd: alu_wd};
    assign ld_req  = '{rd: ld_rd,  wd: ld_wd};

    // Grants depend only on the valids and the round-robin history, never on payload.
    always_comb begin
        grant_alu = 1'b0;
        grant_ld  = 1'b0;
        if (PRIO_MODE == PRIO_FIXED) begin
            grant_ld  = ld_valid;
            grant_alu = alu_valid & ~ld_valid;
        end else if (alu_valid && ld_valid) begin
            grant_ld  = (rr_last == SRC_ALU);
            grant_alu = (rr_last == SRC_LD);
        end else begin
            grant_alu = alu_valid;
            grant_ld  = ld_valid;
        end
    end

    assign alu_ready = grant_alu;
    assign ld_ready  = grant_ld;
    assign grant     = grant_alu | grant_ld;
    assign win_req   = grant_ld ? ld_req : alu_req;
    assign commit_c  = grant && (win_req.rd != REG_IDX_W'(0));

    always_comb begin
        rr_last_nxt = rr_last;
        if (grant) begin
            rr_last_nxt = grant_ld ? SRC_LD : SRC_ALU;
        end
    end

    // Commit register: x0 writes finish the handshake but never raise RFwr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= SRC_ALU;
            RFwr    <= 1'b0;
            rd      <= '0;
            WD      <= '0;
        end else begin
            rr_last <= rr_last_nxt;
            RFwr    <= commit_c;
            if (commit_c) begin
                rd <= win_req.rd;
                WD <= win_req.wd;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .rsv_ready (rsv_ready),
        .clr_en    (RFwr),
        .clr_idx   (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter, round-robin and fixed-priority instances.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, ld_valid, rsv_valid;
    logic [4:0]  alu_rd, ld_rd, rsv_rd, rs1, rs2;
    logic [31:0] alu_wd, ld_wd;

    logic [1:0]  alu_ready, ld_ready, rsv_ready, rs1_busy, rs2_busy, rf_wr;
    logic [4:0]  rd_o [2];
    logic [31:0] wd_o [2];

    int n_checks = 0;
    int n_err    = 0;

    // reference state, index 0 = round-robin, 1 = fixed priority
    bit          m_pend [2][32];
    bit          m_last_ld [2];
    bit          m_wr [2];
    logic [4:0]  m_rd [2];
    logic [31:0] m_wd [2];
    bit          g_alu, g_ld;

    always #5 clk = ~clk;

    rf_write_arbiter #(.PRIO_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready[0]), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .ld_valid(ld_valid), .ld_ready(ld_ready[0]), .ld_rd(ld_rd), .ld_wd(ld_wd),
        .rsv_valid(rsv_valid), .rsv_ready(rsv_ready[0]), .rsv_rd(rsv_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy[0]), .rs2_busy(rs2_busy[0]),
        .RFwr(rf_wr[0]), .rd(rd_o[0]), .WD(wd_o[0])
    );

    rf_write_arbiter #(.PRIO_MODE(1)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready[1]), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .ld_valid(ld_valid), .ld_ready(ld_ready[1]), .ld_rd(ld_rd), .ld_wd(ld_wd),
        .rsv_valid(rsv_valid), .rsv_ready(rsv_ready[1]), .rsv_rd(rsv_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy[1]), .rs2_busy(rs2_busy[1]),
        .RFwr(rf_wr[1]), .rd(rd_o[1]), .WD(wd_o[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 32; r++) m_pend[m][r] = 1'b0;
            m_last_ld[m] = 1'b0;
            m_wr[m]      = 1'b0;
            m_rd[m]      = '0;
            m_wd[m]      = '0;
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 0; ld_valid = 0; rsv_valid = 0;
        alu_rd = 0; ld_rd = 0; rsv_rd = 0; rs1 = 0; rs2 = 0;
        alu_wd = 0; ld_wd = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // One cycle: check combinational outputs mid-cycle, advance the model, check the commit.
    task automatic step();
        bit ea, el, er;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            if (m == 1) begin
                el = ld_valid;
                ea = alu_valid && !ld_valid;
            end else begin
                el = ld_valid && (!alu_valid || !m_last_ld[m]);
                ea = alu_valid && (!ld_valid || m_last_ld[m]);
            end
            er = !m_pend[m][rsv_rd];
            check_eq($sformatf("m%0d alu_ready", m), 32'(alu_ready[m]), 32'(ea));
            check_eq($sformatf("m%0d ld_ready", m), 32'(ld_ready[m]), 32'(el));
            check_eq($sformatf("m%0d rsv_ready", m), 32'(rsv_ready[m]), 32'(er));
            check_eq($sformatf("m%0d rs1_busy", m), 32'(rs1_busy[m]), 32'(m_pend[m][rs1]));
            check_eq($sformatf("m%0d rs2_busy", m), 32'(rs2_busy[m]), 32'(m_pend[m][rs2]));
            if (m_wr[m]) m_pend[m][m_rd[m]] = 1'b0;
            if (rsv_valid && er && rsv_rd != 0) m_pend[m][rsv_rd] = 1'b1;
            m_wr[m] = 1'b0;
            if (ea || el) begin
                m_last_ld[m] = el;
                if ((el ? ld_rd : alu_rd) != 0) begin
                    m_wr[m] = 1'b1;
                    m_rd[m] = el ? ld_rd : alu_rd;
                    m_wd[m] = el ? ld_wd : alu_wd;
                end
            end
            if (m == 0) begin
                g_alu = ea;
                g_ld  = el;
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("m%0d RFwr", m), 32'(rf_wr[m]), 32'(m_wr[m]));
            if (m_wr[m]) begin
                check_eq($sformatf("m%0d rd", m), 32'(rd_o[m]), 32'(m_rd[m]));
                check_eq($sformatf("m%0d WD", m), wd_o[m], m_wd[m]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        do_reset();
        for (int m = 0; m < 2; m++) begin
            check_eq("reset RFwr", 32'(rf_wr[m]), 0);
            check_eq("reset rd", 32'(rd_o[m]), 0);
            check_eq("reset WD", wd_o[m], 0);
        end

        // Single ALU write with one-cycle commit latency
        alu_valid = 1; alu_rd = 5; alu_wd = 32'hDEADBEEF;
        step();
        check_eq("t2 alu granted", 32'(g_alu), 1);
        check_eq("t2 RFwr", 32'(rf_wr[0]), 1);
        check_eq("t2 rd", 32'(rd_o[0]), 5);
        check_eq("t2 WD", wd_o[0], 32'hDEADBEEF);
        idle_inputs();
        step();
        check_eq("t2 RFwr drops", 32'(rf_wr[0]), 0);

        // Async reset mid-burst with a pending register and RFwr high
        rsv_valid = 1; rsv_rd = 3; rs1 = 3;
        step();
        rsv_valid = 0; alu_valid = 1; alu_rd = 3; alu_wd = 32'hCAFE0003;
        step();
        check_eq("t1 pre busy", 32'(rs1_busy[0]), 1);
        check_eq("t1 pre RFwr", 32'(rf_wr[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check_eq("t1 async RFwr", 32'(rf_wr[m]), 0);
            check_eq("t1 async rd", 32'(rd_o[m]), 0);
            check_eq("t1 async WD", wd_o[m], 0);
            check_eq("t1 async busy", 32'(rs1_busy[m]), 0);
        end
        do_reset();
        rs1 = 3;
        #1 check_eq("t1 busy after release", 32'(rs1_busy[0]), 0);

        // Contention: round-robin alternates starting with load, fixed keeps load
        alu_valid = 1; alu_rd = 1; alu_wd = 32'h11;
        ld_valid  = 1; ld_rd  = 2; ld_wd  = 32'h22;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t3 rr load grant", 32'(g_ld), 32'((i % 2) == 0));
            check_eq("t3 fixed alu wait", 32'(alu_ready[1]), 0);
        end
        idle_inputs();
        step();

        // Scoreboard reserve, WAW stall and clear after load commit
        rsv_valid = 1; rsv_rd = 7;
        step();
        rs1 = 7;
        step();
        check_eq("t4 busy", 32'(rs1_busy[0]), 1);
        rsv_valid = 0; ld_valid = 1; ld_rd = 7; ld_wd = 32'h77;
        step();
        ld_valid = 0;
        step();
        check_eq("t4 busy cleared", 32'(rs1_busy[0]), 0);

        // Same-edge set and clear of r9: set wins
        alu_valid = 1; alu_rd = 9; alu_wd = 32'h99;
        step();
        alu_valid = 0; rsv_valid = 1; rsv_rd = 9;
        step();
        rsv_valid = 0; rs1 = 9;
        #1 check_eq("t5 pend9 kept", 32'(rs1_busy[0]), 1);
        step();

        // x0: handshake without write, reservation accepted without pending
        alu_valid = 1; alu_rd = 0; alu_wd = 32'h1234;
        step();
        check_eq("t6 x0 granted", 32'(g_alu), 1);
        check_eq("t6 x0 RFwr", 32'(rf_wr[0]), 0);
        alu_valid = 0; rsv_valid = 1; rsv_rd = 0; rs1 = 0;
        step();
        check_eq("t6 x0 not busy", 32'(rs1_busy[0]), 0);

        // Random traffic honouring hold-until-ready on the round-robin instance
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (!alu_valid || g_alu) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd    = 5'($urandom_range(0, 11));
                alu_wd    = $urandom;
            end
            if (!ld_valid || g_ld) begin
                ld_valid = ($urandom_range(0, 2) != 0);
                ld_rd    = 5'($urandom_range(0, 11));
                ld_wd    = $urandom;
            end
            rsv_valid = $urandom_range(0, 1) == 1;
            rsv_rd    = 5'($urandom_range(0, 11));
            rs1       = 5'($urandom_range(0, 11));
            rs2       = 5'($urandom_range(0, 31));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
